// File: rtl/mul_arb_pkg.sv
// Shared types and partial-product recombination for the multiplier cell arbiter.
package mul_arb_pkg;

  localparam int unsigned MUL_W  = 32;
  localparam int unsigned HALF_W = 16;

  typedef logic [MUL_W-1:0] mul_word_t;

  // Low 32 bits of a 32x32 product from the three partials the cell provides.
  function automatic mul_word_t combine_partials(input mul_word_t p1,
                                                 input mul_word_t p2,
                                                 input mul_word_t p3);
    mul_word_t mid;
    mid = p2 + p3;
    return p1 + (mid << HALF_W);
  endfunction

endpackage

// File: rtl/mul_cell_arbiter_rr_picker.sv
// Combinational round-robin picker: first request after last_grant, circularly.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic        found;
  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant) + k) % NUM_REQ;
      if (enable && !found && req[IDX_W'(cand)]) begin
        grant[IDX_W'(cand)] = 1'b1;
        idx                 = ID_W'(cand);
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_cell_arbiter.sv
// Shares one 3-partial 16x16 multiplier cell among NUM_REQ requesters; tagged 32-bit results.
// Optional counters stat_grants/stat_stalls when MUL_CELL_ARBITER_STATS_EN is defined.
module mul_cell_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MUL_W-1:0] req_src1,
  input  logic [NUM_REQ*MUL_W-1:0] req_src2,
  output mul_word_t                cell_src1,
  output mul_word_t                cell_src2,
  output logic                     cell_en,
  input  mul_word_t                cell_p1,
  input  mul_word_t                cell_p2,
  input  mul_word_t                cell_p3,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output mul_word_t                rsp_data
`ifdef MUL_CELL_ARBITER_STATS_EN
  ,
  output logic [MUL_W-1:0]         stat_grants,
  output logic [MUL_W-1:0]         stat_stalls
`endif
);

  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               adv1;
  logic               adv2;
  logic               pick_en;
  logic               handshake;

  assign adv2      = ~rsp_valid | rsp_ready;
  assign adv1      = ~s1_valid | adv2;
  assign pick_en   = adv1 & ~reset;
  assign cell_en   = pick_en;
  assign req_ready = grant;
  assign handshake = |grant;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (pick_en),
    .grant      (grant),
    .idx        (grant_idx)
  );

  // Operand mux; zero when nothing is granted so the cell inputs stay quiet.
  always_comb begin
    cell_src1 = '0;
    cell_src2 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        cell_src1 = cell_src1 | req_src1[i*MUL_W +: MUL_W];
        cell_src2 = cell_src2 | req_src2[i*MUL_W +: MUL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= handshake;
        if (handshake) s1_id <= grant_idx;
      end
      if (handshake) last_grant <= grant_idx;
      if (adv2) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_id   <= s1_id;
          rsp_data <= combine_partials(cell_p1, cell_p2, cell_p3);
        end
      end
    end
  end

`ifdef MUL_CELL_ARBITER_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (handshake && (stat_grants != '1)) stat_grants <= stat_grants + 32'd1;
      if ((|req_valid) && !handshake && (stat_stalls != '1)) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mul_cell_arbiter.md
Name: mul_cell_arbiter

Overview:
- Shares one 3-partial-product 16x16 multiplier cell (p1 = a.lo*b.lo, p2 = a.lo*b.hi, p3 = a.hi*b.lo, one registered stage gated by M_en) among NUM_REQ requesters.
- Round-robin arbitration per cycle, issue of operands to the cell, and pipeline tracking.
- Recombines the partials into the low 32 bits of a 32x32 product and returns it on a single tagged response channel with backpressure.
- Sits beside the CPU multiplier cell so accelerator blocks (e.g. the IDCT scaler) can borrow it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of response requester ID; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_src1  in  NUM_REQ*32  operand A, packed, requester i at [32*i+:32]
- req_src2  in  NUM_REQ*32  operand B, packed
- cell_src1  out  32  to cell E_src1
- cell_src2  out  32  to cell E_src2
- cell_en  out  1  to cell M_en
- cell_p1  in  32  from cell M_mul_cell_p1
- cell_p2  in  32  from cell M_mul_cell_p2
- cell_p3  in  32  from cell M_mul_cell_p3
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_W  index of originating requester
- rsp_data  out  32  (A*B) mod 2^32

Behaviour:
- Pipeline stages:
  - S0: issue, combinational grant; operands muxed onto cell_src*.
  - S1: cell's internal register; controller holds s1_valid and s1_id.
  - S2: combine register; holds rsp_valid, rsp_id, rsp_data.
- Advance conditions:
  - adv2 = ~rsp_valid | rsp_ready.
  - adv1 = ~s1_valid | adv2.
  - cell_en = adv1; the cell register loads only when S1 advances.
- Grant:
  - When adv1 = 1, the first requester with req_valid set, searching circularly from last_grant+1, gets req_ready = 1.
  - When adv1 = 0, req_ready = 0 for all requesters.
  - Handshake completes on req_valid & req_ready.
  - last_grant updates only on a completed handshake.
- On adv1:
  - s1_valid <= |(req_valid & req_ready).
  - s1_id <= granted index.
- On adv2:
  - rsp_valid <= s1_valid.
  - If s1_valid: rsp_id <= s1_id and rsp_data <= cell_p1 + ((cell_p2 + cell_p3) << 16), truncated to 32 bits; all adds are modulo 2^32.
- Latency and throughput:
  - Handshake at cycle t gives rsp_valid at t+2 when there is no backpressure.
  - Full throughput is one result per cycle.
- Backpressure:
  - rsp_valid held with rsp_ready = 0 freezes rsp_*. If s1_valid is also set, S1 freezes (cell_en = 0) and no grants are made.
  - A bubble in S1 is filled even while S2 is stalled. Capacity is 2 in-flight results.
- Output hold: rsp_data and rsp_id are stable while rsp_valid & ~rsp_ready.
- Idle drive: when no grant, cell_src1/cell_src2 = 0, which keeps cell inputs quiet for power.
- Reset:
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, s1_valid = 0, last_grant = NUM_REQ-1 (so requester 0 has first priority).
  - req_ready = 0 and cell_en = 0 while reset is asserted.
  - Reset mid-operation discards in-flight results; stale cell register contents are never reported because s1_valid = 0.
- Simultaneous events:
  - All requesters valid: strict rotation 0,1,2,3,0,…
  - A single persistent requester is granted every cycle.
  - rsp_ready rising in the same cycle as a new grant is legal, and both advance.

Optional Feature:
- Macro: MUL_CELL_ARBITER_STATS_EN.
- Defined:
  - Adds output stat_grants (32) counting completed handshakes.
  - Adds output stat_stalls (32) counting cycles with any req_valid set and no req_ready.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mul_arb_pkg:
  - constant MUL_W = 32, HALF_W = 16.
  - typedef mul_word_t (32-bit).
  - function combine_partials(p1, p2, p3).
- One sub-module, rr_picker:
  - Inputs: NUM_REQ-wide request vector, last_grant, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.

Test Plan:
- Single request: req0 with A = 0x00010002, B = 0x00030004 at cycle t, rsp_ready = 1 → rsp_valid at t+2, rsp_id = 0, rsp_data = 0x000A0008.
- Wrap-around: A = B = 0xFFFFFFFF from req2 → rsp_data = 0x00000001, rsp_id = 2.
- Fairness: all 4 requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; 8 results in the same order, one per cycle.
- Backpressure: stream from req1 with rsp_ready held low 5 cycles → rsp_* frozen, exactly 2 in flight, cell_en = 0 and req_ready = 0 during stall; no loss or duplication after release.
- Reset mid-flight: assert reset with s1_valid = 1 and rsp_valid = 1 → next cycle rsp_valid = 0, no spurious response afterwards, and a new req from requester 0 is granted first.
- Stats (MUL_CELL_ARBITER_STATS_EN defined): 10 handshakes plus 3 stall cycles → stat_grants = 10, stat_stalls = 3.
